// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: reset/redirect PCs,
// exception code width and encoding, and the stall-counter saturation helper.
package pipe_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;
  localparam int unsigned EXC_W_DEFAULT    = 5;
  localparam logic [15:0] STALL_MAX        = 16'hFFFF;

  // CP0 Cause.ExcCode values carried in out_exc
  typedef enum logic [EXC_W_DEFAULT-1:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == STALL_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid holding register with the same field set as the stage word.
// Only compiled when PIPE_SKID_EN is defined.
`ifdef PIPE_SKID_EN
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned EXC_W  = EXC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_kill,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic [31:0]       i_pc,
  input  logic [EXC_W-1:0]  i_exc,
  input  logic              i_bd,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [EXC_W-1:0]  o_exc,
  output logic              o_bd,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [EXC_W-1:0]  r_exc;
  logic              r_bd;
  logic [DATA_W-1:0] r_data;

  logic              w_nxt_valid;
  logic [31:0]       w_nxt_pc;
  logic [EXC_W-1:0]  w_nxt_exc;
  logic              w_nxt_bd;
  logic [DATA_W-1:0] w_nxt_data;

  // Next-state: kill wins over load; load and unload never coincide.
  always_comb begin
    w_nxt_valid = r_valid;
    w_nxt_pc    = r_pc;
    w_nxt_exc   = r_exc;
    w_nxt_bd    = r_bd;
    w_nxt_data  = r_data;
    if (i_kill) begin
      w_nxt_valid = 1'b0;
      w_nxt_pc    = 32'h0000_0000;
      w_nxt_exc   = '0;
      w_nxt_bd    = 1'b0;
      w_nxt_data  = '0;
    end else if (i_load) begin
      w_nxt_valid = 1'b1;
      w_nxt_pc    = i_pc;
      w_nxt_exc   = i_exc;
      w_nxt_bd    = i_bd;
      w_nxt_data  = i_data;
    end else if (i_unload) begin
      w_nxt_valid = 1'b0;
    end else begin
      w_nxt_valid = r_valid;
    end
  end

  // Skid state register, cleared asynchronously by clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0000_0000;
      r_exc   <= '0;
      r_bd    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_pc    <= w_nxt_pc;
      r_exc   <= w_nxt_exc;
      r_bd    <= w_nxt_bd;
      r_data  <= w_nxt_data;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_exc   = r_exc;
  assign o_bd    = r_bd;
  assign o_data  = r_data;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, exception redirect,
// synchronous flush and saturating stall counter. PIPE_SKID_EN adds a skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned EXC_W    = EXC_W_DEFAULT,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] PC_EXC   = PC_EXC_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt
);

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [EXC_W-1:0]  r_exc;
  logic              r_bd;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_stall_cnt;

  logic              w_nxt_valid;
  logic [31:0]       w_nxt_pc;
  logic [EXC_W-1:0]  w_nxt_exc;
  logic              w_nxt_bd;
  logic [DATA_W-1:0] w_nxt_data;

  logic w_in_fire;
  logic w_load;
  logic w_stall;

  assign w_in_fire = in_valid & in_ready;
  assign w_load    = ~r_valid | out_ready;
  assign w_stall   = r_valid & ~out_ready;

`ifdef PIPE_SKID_EN
  logic              w_skid_valid;
  logic [31:0]       w_skid_pc;
  logic [EXC_W-1:0]  w_skid_exc;
  logic              w_skid_bd;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_kill;
  logic              w_skid_load;
  logic              w_skid_unload;

  // Skid only catches words that arrive while the main register is stalled.
  assign w_skid_kill   = req | flush;
  assign w_skid_load   = w_in_fire & ~w_load;
  assign w_skid_unload = w_load & w_skid_valid;
  assign in_ready      = ~w_skid_valid;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .EXC_W  (EXC_W)
  ) u_skid (
    .clk      (clk),
    .clr      (clr),
    .i_kill   (w_skid_kill),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_pc     (in_pc),
    .i_exc    (in_exc),
    .i_bd     (in_bd),
    .i_data   (in_data),
    .o_valid  (w_skid_valid),
    .o_pc     (w_skid_pc),
    .o_exc    (w_skid_exc),
    .o_bd     (w_skid_bd),
    .o_data   (w_skid_data)
  );
`else
  assign in_ready = ~r_valid | out_ready;
`endif

  // Main register next-state: req, then flush, then normal transfer.
  always_comb begin
    w_nxt_valid = r_valid;
    w_nxt_pc    = r_pc;
    w_nxt_exc   = r_exc;
    w_nxt_bd    = r_bd;
    w_nxt_data  = r_data;
    if (req) begin
      w_nxt_valid = 1'b0;
      w_nxt_pc    = PC_EXC;
      w_nxt_exc   = '0;
      w_nxt_bd    = 1'b0;
      w_nxt_data  = '0;
    end else if (flush) begin
      w_nxt_valid = 1'b0;
      w_nxt_exc   = '0;
      w_nxt_bd    = 1'b0;
      w_nxt_data  = '0;
    end else if (w_load) begin
`ifdef PIPE_SKID_EN
      // A parked word is older than anything on in_*, so it goes first.
      if (w_skid_valid) begin
        w_nxt_valid = 1'b1;
        w_nxt_pc    = w_skid_pc;
        w_nxt_exc   = w_skid_exc;
        w_nxt_bd    = w_skid_bd;
        w_nxt_data  = w_skid_data;
      end else if (w_in_fire) begin
        w_nxt_valid = 1'b1;
        w_nxt_pc    = in_pc;
        w_nxt_exc   = in_exc;
        w_nxt_bd    = in_bd;
        w_nxt_data  = in_data;
      end else begin
        w_nxt_valid = 1'b0;
      end
`else
      if (w_in_fire) begin
        w_nxt_valid = 1'b1;
        w_nxt_pc    = in_pc;
        w_nxt_exc   = in_exc;
        w_nxt_bd    = in_bd;
        w_nxt_data  = in_data;
      end else begin
        w_nxt_valid = 1'b0;
      end
`endif
    end else begin
      w_nxt_valid = r_valid;
    end
  end

  // Main stage register, cleared asynchronously by clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_valid <= 1'b0;
      r_pc    <= PC_RESET;
      r_exc   <= '0;
      r_bd    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_pc    <= w_nxt_pc;
      r_exc   <= w_nxt_exc;
      r_bd    <= w_nxt_bd;
      r_data  <= w_nxt_data;
    end
  end

  // Stall counter survives req and flush; only clr zeroes it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall) begin
      r_stall_cnt <= sat_inc16(r_stall_cnt);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign out_exc   = r_exc;
  assign out_bd    = r_bd;
  assign out_data  = r_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register carrying a PC, exception code, branch-delay flag and a generic payload between two CPU stages. It replaces fixed-field per-stage registers such as the E→M register, and adds a valid/ready handshake, an exception redirect, a synchronous flush and a stall-cycle counter. One instance sits on each stage boundary (D→E, E→M, M→W).

## Interface
- DATA_W, 128: payload width in bits (instr, pc8, ext, operands, ALU/MDU results packed by the instantiating stage)
- EXC_W, 5: exception code width
- PC_RESET, 32'h0000_3000: out_pc value after clr
- PC_EXC, 32'h0000_4180: out_pc value loaded on req
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- req  in  1  exception redirect, synchronous
- flush  in  1  kill stage contents, synchronous
- in_valid  in  1  upstream has a stage word
- in_ready  out  1  stage accepts a word this cycle
- in_pc  in  32  upstream PC
- in_exc  in  EXC_W  upstream exception code
- in_bd  in  1  upstream branch-delay flag
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage word held
- out_ready  in  1  downstream consumes the word
- out_pc, out_exc, out_bd, out_data  out  32/EXC_W/1/DATA_W  registered stage word
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority, highest first: clr, req, flush, normal transfer.
- clr: out_valid=0, out_pc=PC_RESET, out_exc=0, out_bd=0, out_data=0, skid empty, stall_cnt=0.
- req: next edge out_valid=0, out_pc=PC_EXC, out_exc/out_bd/out_data=0, skid emptied; the word on in_* that cycle is dropped even if in_fire.
- flush (without req): out_valid=0, out_exc/out_bd/out_data=0, out_pc retained, skid emptied, in_* dropped.
- Normal: main register loads when ~out_valid | out_ready. On in_fire it takes in_*; on out_fire with no new word, out_valid←0 with payload retained.
- While out_valid & ~out_ready, all out_* are held stable.
- stall_cnt increments each cycle with out_valid & ~out_ready; saturates at 16'hFFFF; cleared by clr only (not by req or flush).

## Timing
- Latency: in_fire at edge N → out_valid=1 with that word after edge N; throughput one word per cycle.
- Without skid: in_ready = ~out_valid | out_ready (combinational from out_ready).
- With skid: in_ready = ~skid_valid, registered; no combinational path out_ready→in_ready.
- The skid drains into the main register before new input is accepted; ordering is strictly FIFO.
- in_ready does not depend on req or flush; a word accepted in a req or flush cycle is discarded.
- clr asserted mid-transfer discards the main register and skid immediately, without waiting for a clock edge.

## Configuration
- PIPE_SKID_EN defined: one-entry skid buffer present. With main full and out_ready=0, an in_fire word parks in the skid. in_ready falls only when the skid is full, on the edge after that fill.
- PIPE_SKID_EN undefined: no skid and no skid state. in_ready is combinational as above, and the stage holds at most one word.

## Structure
- Shared package pipe_pkg: PC_RESET_DEFAULT, PC_EXC_DEFAULT, EXC_W_DEFAULT, and exc_code_t enum (Int, AdEL, AdES, RI, Ov, Syscall codes).
- Sub-module pipe_skid_buf: one-entry holding register with the same field set, instantiated only under PIPE_SKID_EN.

## Test plan
- clr pulse mid-cycle → outputs drop without a clock edge: out_pc=32'h3000, out_valid=0, stall_cnt=0.
- Streaming: in_valid=1 for 4 cycles, out_ready=1, in_pc=0x3000,0x3004,0x3008,0x300C → the same PCs appear on out_pc one cycle later, out_valid continuous.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_* stable and stall_cnt=3. With PIPE_SKID_EN, one extra word is accepted and delivered second after release.
- req with in_fire, in_pc=0x3010 → next cycle out_valid=0, out_pc=0x4180, out_exc=0; 0x3010 never appears on the output.
- flush while holding 0x3020 with out_ready=0 → out_valid=0, out_pc=0x3020, out_data=0, skid empty.
- Saturation: hold out_valid=1, out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF and no wrap.
